// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and sequencer that shares one UART transmitter between two byte sources.
// Define UART_TX_ARB_GAP_EN to build the inter-frame guard gap (GAP state plus 8-bit baud tick counter).
module uart_tx_arbiter #(
    parameter int DBIT      = 8,
    parameter int GAP_TICKS = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_baud_tick,
    input  logic            i_req0,
    input  logic [DBIT-1:0] i_data0,
    output logic            o_ack0,
    input  logic            i_req1,
    input  logic [DBIT-1:0] i_data1,
    output logic            o_ack1,
    output logic            o_tx_start,
    output logic [DBIT-1:0] o_tx_data,
    input  logic            i_tx_done,
    output logic            o_busy
);

`ifdef UART_TX_ARB_GAP_EN
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } state_t;

    localparam logic [7:0] GAP_LIMIT = 8'(GAP_TICKS);

    logic [7:0] gap_cnt;
    logic [7:0] gap_cnt_d;
`else
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1
    } state_t;

    logic unused_gap;
    assign unused_gap = i_baud_tick | (GAP_TICKS == 0);
`endif

    state_t          state;
    state_t          state_d;
    logic            ack0_d;
    logic            ack1_d;
    logic            start_d;
    logic [DBIT-1:0] tx_data_d;
    logic            last_grant;
    logic            last_grant_d;
    logic            grant0;
    logic            grant1;

    // Handshake: a requester holds req/data stable until it sees its ack; the ack
    // cycle alone consumes the byte, and dropping req before ack withdraws it.
    // On a tie the requester that was not granted last wins.
    assign grant1 = i_req1 && (!i_req0 || !last_grant);
    assign grant0 = i_req0 && !grant1;

    always_comb begin
        state_d      = state;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        start_d      = 1'b0;
        tx_data_d    = o_tx_data;
        last_grant_d = last_grant;
`ifdef UART_TX_ARB_GAP_EN
        gap_cnt_d    = gap_cnt;
`endif
        case (state)
            IDLE: begin
                if (grant0 || grant1) begin
                    ack0_d       = grant0;
                    ack1_d       = grant1;
                    start_d      = 1'b1;
                    tx_data_d    = grant1 ? i_data1 : i_data0;
                    last_grant_d = grant1;
                    state_d      = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_tx_done) begin
`ifdef UART_TX_ARB_GAP_EN
                    // A tick coinciding with done is deliberately not counted.
                    state_d   = GAP;
                    gap_cnt_d = 8'd0;
`else
                    state_d   = IDLE;
`endif
                end
            end
`ifdef UART_TX_ARB_GAP_EN
            GAP: begin
                if (i_baud_tick) begin
                    gap_cnt_d = gap_cnt + 8'd1;
                    if (gap_cnt + 8'd1 == GAP_LIMIT) begin
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            o_ack0     <= 1'b0;
            o_ack1     <= 1'b0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_busy     <= 1'b0;
            last_grant <= 1'b1;
`ifdef UART_TX_ARB_GAP_EN
            gap_cnt    <= 8'd0;
`endif
        end else begin
            state      <= state_d;
            o_ack0     <= ack0_d;
            o_ack1     <= ack1_d;
            o_tx_start <= start_d;
            o_tx_data  <= tx_data_d;
            o_busy     <= (state_d != IDLE);
            last_grant <= last_grant_d;
`ifdef UART_TX_ARB_GAP_EN
            gap_cnt    <= gap_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single grant, tie round-robin, withdrawal,
// reset mid-frame and frame spacing (gap build when UART_TX_ARB_GAP_EN is defined).
module tb_uart_tx_arbiter;
    localparam int DBIT      = 8;
    localparam int GAP_TICKS = 16;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic            auto_tick = 1'b0;
    logic            man_tick  = 1'b0;
    logic            tick;
    logic            req0      = 1'b0;
    logic            req1      = 1'b0;
    logic [DBIT-1:0] data0     = '0;
    logic [DBIT-1:0] data1     = '0;
    logic            tx_done   = 1'b0;
    logic            ack0;
    logic            ack1;
    logic            tx_start;
    logic [DBIT-1:0] tx_data;
    logic            busy;

    int              n_vec     = 0;
    int              n_err     = 0;
    bit              auto_en   = 1'b0;
    int              tick_div  = 0;
    logic [DBIT-1:0] exp_q[$];

    assign tick = auto_tick | man_tick;

    uart_tx_arbiter #(.DBIT(DBIT), .GAP_TICKS(GAP_TICKS)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_baud_tick(tick),
        .i_req0     (req0),
        .i_data0    (data0),
        .o_ack0     (ack0),
        .i_req1     (req1),
        .i_data1    (data1),
        .o_ack1     (ack1),
        .o_tx_start (tx_start),
        .o_tx_data  (tx_data),
        .i_tx_done  (tx_done),
        .o_busy     (busy)
    );

    // clock/reset block
    always #5 clk = ~clk;

    // free-running baud tick, one pulse every 54 cycles while enabled
    initial forever begin
        @(posedge clk);
        #1;
        if (auto_en) begin
            tick_div  = (tick_div == 53) ? 0 : tick_div + 1;
            auto_tick = (tick_div == 0);
        end else begin
            auto_tick = 1'b0;
            tick_div  = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic a0, input logic a1,
                              input logic st, input logic bz);
        check({tag, "_ack0"}, 32'(ack0), 32'(a0));
        check({tag, "_ack1"}, 32'(ack1), 32'(a1));
        check({tag, "_start"}, 32'(tx_start), 32'(st));
        check({tag, "_busy"}, 32'(busy), 32'(bz));
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        auto_en = 1'b0;
        req0    = 1'b0;
        req1    = 1'b0;
        tx_done = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_start(input int limit);
        int k;
        k = 0;
        while (!tx_start && k < limit) begin
            step();
            k++;
        end
        if (!tx_start) check("start_timeout", 32'(tx_start), 1);
    endtask

    initial begin
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
        check_outs("reset", 0, 0, 0, 0);
        check("reset_data", 32'(tx_data), 0);

        // single requester
        req0 = 1'b1; data0 = 8'h41;
        step();
        check_outs("single_grant", 1, 0, 1, 1);
        check("single_data", 32'(tx_data), 'h41);
        req0 = 1'b0; data0 = 8'h00;
        step();
        check_outs("single_after", 0, 0, 0, 1);
        check("single_hold", 32'(tx_data), 'h41);
        steps(5);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
`ifndef UART_TX_ARB_GAP_EN
        check_outs("single_done", 0, 0, 0, 0);
`else
        check("single_gap_busy", 32'(busy), 1);
`endif

        // withdrawal while busy
        do_reset();
        req0 = 1'b1; data0 = 8'h5A;
        step();
        check("withdraw_first_ack0", 32'(ack0), 1);
        req0 = 1'b0;
        req1 = 1'b1; data1 = 8'hA5;
        repeat (3) begin
            step();
            check_outs("withdraw_busy", 0, 0, 0, 1);
        end
        req1 = 1'b0;
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        repeat (6) begin
            step();
            check("withdraw_ack1", 32'(ack1), 0);
            check("withdraw_start", 32'(tx_start), 0);
        end
`ifndef UART_TX_ARB_GAP_EN
        check("withdraw_idle", 32'(busy), 0);
`endif

        // tie after reset alternates 0,1,0,1
        do_reset();
        auto_en = 1'b1;
        exp_q = {8'h11, 8'h22, 8'h11, 8'h22};
        req0 = 1'b1; data0 = 8'h11;
        req1 = 1'b1; data1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
            wait_start(2000);
            check("tie_ack0", 32'(ack0), (i % 2 == 0) ? 1 : 0);
            check("tie_ack1", 32'(ack1), (i % 2 == 1) ? 1 : 0);
            check("tie_data", 32'(tx_data), 32'(exp_q.pop_front()));
            step();
            check("tie_start_pulse", 32'(tx_start), 0);
            steps(8);
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;
        auto_en = 1'b0;

        // reset in WAIT_DONE, then a stray done
        do_reset();
        req0 = 1'b1; data0 = 8'h33;
        step();
        check("rst_pre_ack0", 32'(ack0), 1);
        req0 = 1'b0;
        step();
        rst = 1'b1;
        step();
        check_outs("rst_mid", 0, 0, 0, 0);
        check("rst_mid_data", 32'(tx_data), 0);
        rst = 1'b0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check_outs("rst_stray_done", 0, 0, 0, 0);
        step();
        check_outs("rst_idle", 0, 0, 0, 0);
        req0 = 1'b1; data0 = 8'h11;
        req1 = 1'b1; data1 = 8'h22;
        step();
        check_outs("rst_tie", 1, 0, 1, 1);
        check("rst_tie_data", 32'(tx_data), 'h11);
        req0 = 1'b0; req1 = 1'b0;

`ifdef UART_TX_ARB_GAP_EN
        // guard gap with done/tick coincidence
        do_reset();
        req0 = 1'b1; data0 = 8'hC3;
        step();
        check("gap_first_start", 32'(tx_start), 1);
        step();
        tx_done = 1'b1; man_tick = 1'b1;
        step();
        tx_done = 1'b0; man_tick = 1'b0;
        check("gap_enter_busy", 32'(busy), 1);
        for (int t = 1; t < GAP_TICKS; t++) begin
            man_tick = 1'b1;
            step();
            man_tick = 1'b0;
            steps(3);
            check("gap_tick_start", 32'(tx_start), 0);
            check("gap_tick_busy", 32'(busy), 1);
        end
        man_tick = 1'b1;
        step();
        man_tick = 1'b0;
        check_outs("gap_exit", 0, 0, 0, 0);
        step();
        check_outs("gap_regrant", 1, 0, 1, 1);
        check("gap_regrant_data", 32'(tx_data), 'hC3);
        req0 = 1'b0;
`else
        // spacing without gap: start exactly 2 cycles after the done cycle
        do_reset();
        req0 = 1'b1; data0 = 8'h77;
        step();
        check("nogap_first_start", 32'(tx_start), 1);
        steps(4);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check_outs("nogap_done", 0, 0, 0, 0);
        step();
        check_outs("nogap_regrant", 1, 0, 1, 1);
        check("nogap_regrant_data", 32'(tx_data), 'h77);
        req0 = 1'b0;
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
